// File: rtl/blobby_pkg.sv
// Shared game definitions: player encoding, referee states and court geometry defaults.
package blobby_pkg;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        RALLY = 2'd1,
        HOLD  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int unsigned NET_X_DEF     = 512;
    localparam int unsigned BALL_HALF_DEF = 32;

    // True when the ball centre lies strictly left of the net line.
    function automatic logic ball_left(input logic [11:0] posx, input int unsigned half,
                                       input int unsigned net);
        logic [12:0] centre;
        centre = {1'b0, posx} + 13'(half);
        return centre < 13'(net);
    endfunction

endpackage

// File: rtl/referee_ctrl_if.sv
// Collision inputs, game control and score/rule outputs of the referee.
interface referee_ctrl_if;
    logic        pl1_col;
    logic        pl2_col;
    logic        gnd_col;
    logic [11:0] ball_posx;
    logic        new_game;
    logic        last_touch;
    logic        ovr_touch;
    logic [3:0]  score_pl1;
    logic [3:0]  score_pl2;
    logic        point_won;
    logic        winner;
    logic        game_over;

    // Environment side: drives collisions and game control.
    modport master (
        output pl1_col, pl2_col, gnd_col, ball_posx, new_game,
        input  last_touch, ovr_touch, score_pl1, score_pl2, point_won, winner, game_over
    );

    // Referee side.
    modport slave (
        input  pl1_col, pl2_col, gnd_col, ball_posx, new_game,
        output last_touch, ovr_touch, score_pl1, score_pl2, point_won, winner, game_over
    );
endinterface

// File: rtl/touch_filter.sv
// Rising-edge detector with a ghost window that suppresses repeat edges of one player.
module touch_filter #(
    parameter int unsigned GHOST_CYCLES = 3_250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic col,
    output logic touch
);
    localparam int unsigned GW = (GHOST_CYCLES < 2) ? 1 : $clog2(GHOST_CYCLES + 1);

    logic          col_q;
    logic [GW-1:0] ghost_q;

    // A touch is a fresh rising edge while no ghost window is running.
    always_comb begin
        touch = col & ~col_q & (ghost_q == '0);
    end

    // Edge register and ghost countdown; reloads so the edge GHOST_CYCLES later is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= 1'b0;
            ghost_q <= '0;
        end else begin
            col_q <= col;
            if (clear) begin
                ghost_q <= '0;
            end else if (touch) begin
                ghost_q <= GW'(GHOST_CYCLES - 1);
            end else if (ghost_q != '0) begin
                ghost_q <= ghost_q - GW'(1);
            end
        end
    end

endmodule

// File: rtl/referee_ctrl.sv
// Game-rule controller: tracks possession, detects over-touch, awards points, keeps score.
module referee_ctrl
    import blobby_pkg::*;
#(
    parameter int unsigned NET_X        = NET_X_DEF,
    parameter int unsigned BALL_HALF    = BALL_HALF_DEF,
    parameter int unsigned MAX_TOUCH    = 3,
    parameter int unsigned GHOST_CYCLES = 3_250_000,
    parameter int unsigned HOLD_CYCLES  = 170_000_000,
    parameter int unsigned WIN_SCORE    = 15
) (
    input logic           clk,
    input logic           rst,
    referee_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(MAX_TOUCH + 2);
    localparam int unsigned HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [3:0]  WIN4 = 4'(WIN_SCORE);

    state_t        state_q, state_d;
    logic          hitter_q, hitter_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    score1_q, score1_d;
    logic [3:0]    score2_q, score2_d;
    logic          last_touch_q, last_touch_d;
    logic          ovr_q, ovr_d;
    logic          point_q, point_d;
    logic          winner_q, winner_d;
    logic          over_q, over_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          gnd_q;

    logic          t1_raw, t2_raw;
    logic          touch1, touch2, touch_any, who;
    logic          gnd_rise;
    logic          filt_clear;
    logic          award, award_side;
    logic [CW-1:0] next_count;
    logic [3:0]    win_new;

    touch_filter #(.GHOST_CYCLES(GHOST_CYCLES)) u_filt1 (
        .clk   (clk),
        .rst   (rst),
        .clear (filt_clear),
        .col   (bus.pl1_col),
        .touch (t1_raw)
    );

    touch_filter #(.GHOST_CYCLES(GHOST_CYCLES)) u_filt2 (
        .clk   (clk),
        .rst   (rst),
        .clear (filt_clear),
        .col   (bus.pl2_col),
        .touch (t2_raw)
    );

    // Simultaneous touches from both players cancel each other.
    always_comb begin
        touch1    = t1_raw & ~t2_raw;
        touch2    = t2_raw & ~t1_raw;
        touch_any = touch1 | touch2;
        who       = touch2 ? PLAYER2 : PLAYER1;
        gnd_rise  = bus.gnd_col & ~gnd_q;
    end

    // Next-state, possession, point award and new-game override.
    always_comb begin
        state_d      = state_q;
        hitter_d     = hitter_q;
        count_d      = count_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        last_touch_d = last_touch_q;
        ovr_d        = 1'b0;
        point_d      = 1'b0;
        winner_d     = winner_q;
        over_d       = over_q;
        hold_d       = hold_q;
        filt_clear   = 1'b0;
        award        = 1'b0;
        award_side   = PLAYER1;
        next_count   = (hitter_q != who) ? CW'(1) : count_q + CW'(1);
        win_new      = '0;

        unique case (state_q)
            SERVE: begin
                if ((last_touch_q == PLAYER1) ? touch1 : touch2) begin
                    hitter_d = last_touch_q;
                    count_d  = CW'(1);
                    state_d  = RALLY;
                end
            end
            RALLY: begin
                // Ground beats a touch arriving in the same cycle.
                if (gnd_rise) begin
                    award      = 1'b1;
                    award_side = ball_left(bus.ball_posx, BALL_HALF, NET_X) ? PLAYER2 : PLAYER1;
                end else if (touch_any) begin
                    hitter_d = who;
                    count_d  = next_count;
                    if (next_count == CW'(MAX_TOUCH + 1)) begin
                        ovr_d      = 1'b1;
                        award      = 1'b1;
                        award_side = ~who;
                    end
                end
            end
            HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_d     = '0;
                    filt_clear = 1'b1;
                    state_d    = SERVE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            OVER: begin
            end
            default: state_d = SERVE;
        endcase

        if (award) begin
            win_new = (award_side == PLAYER1) ? score1_q : score2_q;
            win_new = (win_new >= WIN4) ? WIN4 : win_new + 4'd1;
            if (award_side == PLAYER1) begin
                score1_d = win_new;
            end else begin
                score2_d = win_new;
            end
            last_touch_d = award_side;
            point_d      = 1'b1;
            count_d      = '0;
            hold_d       = '0;
            if (win_new == WIN4) begin
                state_d  = OVER;
                over_d   = 1'b1;
                winner_d = award_side;
            end else begin
                state_d = HOLD;
            end
        end

        if (bus.new_game) begin
            score1_d     = '0;
            score2_d     = '0;
            count_d      = '0;
            over_d       = 1'b0;
            winner_d     = 1'b0;
            last_touch_d = PLAYER1;
            ovr_d        = 1'b0;
            point_d      = 1'b0;
            state_d      = SERVE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SERVE;
            hitter_q     <= PLAYER1;
            count_q      <= '0;
            score1_q     <= '0;
            score2_q     <= '0;
            last_touch_q <= PLAYER1;
            ovr_q        <= 1'b0;
            point_q      <= 1'b0;
            winner_q     <= 1'b0;
            over_q       <= 1'b0;
            hold_q       <= '0;
            gnd_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hitter_q     <= hitter_d;
            count_q      <= count_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            last_touch_q <= last_touch_d;
            ovr_q        <= ovr_d;
            point_q      <= point_d;
            winner_q     <= winner_d;
            over_q       <= over_d;
            hold_q       <= hold_d;
            gnd_q        <= bus.gnd_col;
        end
    end

    assign bus.last_touch = last_touch_q;
    assign bus.ovr_touch  = ovr_q;
    assign bus.score_pl1  = score1_q;
    assign bus.score_pl2  = score2_q;
    assign bus.point_won  = point_q;
    assign bus.winner     = winner_q;
    assign bus.game_over  = over_q;

endmodule

// File: tb/tb_referee_ctrl.sv
// Self-checking bench for referee_ctrl with small ghost/hold/win parameters.
module tb_referee_ctrl;
    import blobby_pkg::*;

    typedef struct packed {
        logic       lt;
        logic       ovr;
        logic       pt;
        logic       win;
        logic       over;
        logic [3:0] s1;
        logic [3:0] s2;
        state_t     st;
        logic [2:0] cnt;
    } exp_t;

    typedef struct {
        int          pre;
        logic        p1;
        logic        p2;
        logic        g;
        logic [11:0] x;
        logic        ng;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    referee_ctrl_if bus();

    referee_ctrl #(
        .GHOST_CYCLES (8),
        .HOLD_CYCLES  (20),
        .WIN_SCORE    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic p1, input logic p2, input logic g, input logic [11:0] x,
                         input logic ng);
        bus.pl1_col   = p1;
        bus.pl2_col   = p2;
        bus.gnd_col   = g;
        bus.ball_posx = x;
        bus.new_game  = ng;
    endtask

    function automatic exp_t observe();
        exp_t o;
        o.lt   = bus.last_touch;
        o.ovr  = bus.ovr_touch;
        o.pt   = bus.point_won;
        o.win  = bus.winner;
        o.over = bus.game_over;
        o.s1   = bus.score_pl1;
        o.s2   = bus.score_pl2;
        o.st   = dut.state_q;
        o.cnt  = 3'(dut.count_q);
        return o;
    endfunction

    task automatic compare(input string name, input exp_t want);
        exp_t got;
        got = observe();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got lt=%0b ovr=%0b pt=%0b win=%0b over=%0b s1=%0d s2=%0d st=%0d cnt=%0d, expected lt=%0b ovr=%0b pt=%0b win=%0b over=%0b s1=%0d s2=%0d st=%0d cnt=%0d",
                     name, got.lt, got.ovr, got.pt, got.win, got.over, got.s1, got.s2, got.st,
                     got.cnt, want.lt, want.ovr, want.pt, want.win, want.over, want.s1, want.s2,
                     want.st, want.cnt);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    function automatic exp_t mke(input logic lt, input logic ovr, input logic pt, input logic win,
                                 input logic over, input int s1, input int s2, input state_t st,
                                 input int cnt);
        exp_t e;
        e.lt = lt; e.ovr = ovr; e.pt = pt; e.win = win; e.over = over;
        e.s1 = 4'(s1); e.s2 = 4'(s2); e.st = st; e.cnt = 3'(cnt);
        return e;
    endfunction

    task automatic addv(input int pre, input logic p1, input logic p2, input logic g,
                        input int x, input logic ng, input exp_t e);
        vec_t v;
        v.pre = pre; v.p1 = p1; v.p2 = p2; v.g = g; v.x = 12'(x); v.ng = ng; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t want;

        // Stimulus table: idle cycles before, inputs for one cycle, expected state one cycle later.
        addv(2,  0, 1, 0, 0,   0, mke(0, 0, 0, 0, 0, 0, 0, SERVE, 0)); // non-server ignored
        addv(10, 1, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 0, 0, RALLY, 1)); // serve
        addv(10, 1, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 0, 0, RALLY, 2));
        addv(10, 1, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 0, 0, RALLY, 3));
        addv(10, 1, 0, 0, 0,   0, mke(1, 1, 1, 0, 0, 0, 1, HOLD, 0));  // 4th touch
        addv(0,  0, 0, 0, 0,   0, mke(1, 0, 0, 0, 0, 0, 1, HOLD, 0));  // pulses end
        addv(25, 0, 0, 0, 0,   0, mke(1, 0, 0, 0, 0, 0, 1, SERVE, 0));
        addv(2,  1, 0, 0, 0,   0, mke(1, 0, 0, 0, 0, 0, 1, SERVE, 0)); // pl2 serves now
        addv(10, 0, 1, 0, 0,   0, mke(1, 0, 0, 0, 0, 0, 1, RALLY, 1));
        addv(10, 0, 0, 1, 470, 0, mke(1, 0, 1, 0, 0, 0, 2, HOLD, 0));  // centre 502: left
        addv(25, 0, 0, 0, 0,   0, mke(1, 0, 0, 0, 0, 0, 2, SERVE, 0));
        addv(2,  0, 1, 0, 0,   0, mke(1, 0, 0, 0, 0, 0, 2, RALLY, 1));
        addv(10, 0, 0, 1, 480, 0, mke(0, 0, 1, 0, 0, 1, 2, HOLD, 0));  // centre 512: right
        addv(25, 0, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 1, 2, SERVE, 0));
        addv(2,  1, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 1, 2, RALLY, 1)); // +0
        addv(4,  1, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 1, 2, RALLY, 1)); // +5 ghosted
        addv(2,  1, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 1, 2, RALLY, 2)); // +8 accepted
        addv(10, 1, 1, 0, 0,   0, mke(0, 0, 0, 0, 0, 1, 2, RALLY, 2)); // simultaneous
        addv(10, 1, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 1, 2, RALLY, 3));
        addv(10, 1, 0, 1, 600, 0, mke(0, 0, 1, 0, 0, 2, 2, HOLD, 0));  // ground wins
        addv(25, 0, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 2, 2, SERVE, 0));
        addv(2,  1, 0, 0, 0,   0, mke(0, 0, 0, 0, 0, 2, 2, RALLY, 1));
        addv(10, 0, 0, 1, 900, 0, mke(0, 0, 1, 0, 1, 3, 2, OVER, 0));  // game ends
        addv(3,  0, 1, 1, 100, 0, mke(0, 0, 0, 0, 1, 3, 2, OVER, 0));  // ignored
        addv(30, 0, 0, 0, 0,   0, mke(0, 0, 0, 0, 1, 3, 2, OVER, 0));
        addv(2,  0, 0, 0, 0,   1, mke(0, 0, 0, 0, 0, 0, 0, SERVE, 0)); // new game

        drive(0, 0, 0, 12'd0, 0);
        @(negedge clk);
        tick();
        compare("reset", mke(0, 0, 0, 0, 0, 0, 0, SERVE, 0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            repeat (vecs[i].pre) begin
                drive(0, 0, 0, 12'd0, 0);
                tick();
            end
            drive(vecs[i].p1, vecs[i].p2, vecs[i].g, vecs[i].x, vecs[i].ng);
            exp_q.push_back(vecs[i].e);
            tick();
            want = exp_q.pop_front();
            compare($sformatf("row%0d", i), want);
        end

        // Exact HOLD length: SERVE returns on the 21st edge after the ground edge cycle.
        drive(0, 0, 0, 12'd0, 0);
        repeat (2) tick();
        drive(1, 0, 0, 12'd0, 0);
        tick();
        check("hold_serve_taken", 32'(dut.state_q), 32'(RALLY));
        drive(0, 0, 0, 12'd0, 0);
        repeat (10) tick();
        drive(0, 0, 1, 12'd900, 0);
        for (int k = 1; k <= 21; k++) begin
            tick();
            drive(0, 0, 0, 12'd0, 0);
            if (k == 1) begin
                check("hold_point", 32'(bus.point_won), 32'd1);
                check("hold_score1", 32'(bus.score_pl1), 32'd1);
            end
            if (k == 2) check("hold_point_gone", 32'(bus.point_won), 32'd0);
            if (k == 20) check("hold_k20", 32'(dut.state_q), 32'(HOLD));
            if (k == 21) check("hold_k21", 32'(dut.state_q), 32'(SERVE));
        end

        // Reset while holding: every output back to its reset value next cycle.
        repeat (2) tick();
        drive(1, 0, 0, 12'd0, 0);
        tick();
        drive(0, 0, 0, 12'd0, 0);
        repeat (10) tick();
        drive(0, 0, 1, 12'd900, 0);
        tick();
        drive(0, 0, 0, 12'd0, 0);
        compare("pre_rst", mke(0, 0, 1, 0, 0, 2, 0, HOLD, 0));
        repeat (5) tick();
        rst = 1'b1;
        tick();
        compare("rst_hold", mke(0, 0, 0, 0, 0, 0, 0, SERVE, 0));
        check("rst_hold_cnt", 32'(dut.hold_q), 32'd0);
        rst = 1'b0;
        tick();
        compare("post_rst", mke(0, 0, 0, 0, 0, 0, 0, SERVE, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
